// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the raster timing generator.
// Holds the 640x480@60 default geometry, total-length helpers, the
// coordinate width, sync polarity constants and the output register bundle.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned FRAME_W = 16;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Registered output set, kept together so every field shares one edge.
  typedef struct packed {
    logic               de;
    logic               hs;
    logic               vs;
    logic               sol;
    logic               sof;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vga_out_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N counter with enable.
// Ports: i_clk, i_rstn (async active-low), en_i (advance), cnt_o (count),
//        wrap_c_o (combinational: en_i while the count sits at N-1).
module wrap_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned W = COORD_W,
  parameter int unsigned N = 800
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_c_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_c_o = en_i && (cnt_q == W'(N - 1));

  // Next count: hold, increment, or fold back to zero on wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_c_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator (default 640x480@60).
// Ports: i_clk, i_rstn (async active-low), i_en (count enable; low holds
//        everything), o_de, o_hs, o_vs, o_x, o_y, o_sol, o_sof, all
//        registered one cycle behind the internal counters.
// Optional: defining VGA_TIMING_FRAME_CNT_EN adds o_frame, a 16-bit frame
//        count that steps together with o_sof (not on the first frame).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = SYNC_ACTIVE_LOW,
  parameter bit          VS_POL   = SYNC_ACTIVE_LOW
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_en,
  output logic               o_de,
  output logic               o_hs,
  output logic               o_vs,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_sol,
  output logic               o_sof
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0] o_frame
`endif
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // One spare bit so boundaries equal to 2**COORD_W compare correctly.
  localparam int unsigned CMP_W = COORD_W + 1;
  localparam logic [CMP_W-1:0] H_DE_END = CMP_W'(H_ACTIVE);
  localparam logic [CMP_W-1:0] HS_START = CMP_W'(H_ACTIVE + H_FP);
  localparam logic [CMP_W-1:0] HS_END   = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CMP_W-1:0] V_DE_END = CMP_W'(V_ACTIVE);
  localparam logic [CMP_W-1:0] VS_START = CMP_W'(V_ACTIVE + V_FP);
  localparam logic [CMP_W-1:0] VS_END   = CMP_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam vga_out_t OUT_RST = '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL,
                                   sol: 1'b0, sof: 1'b0, x: '0, y: '0};

  if (H_TOTAL > (1 << COORD_W)) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL %0d exceeds the counter range", H_TOTAL);
  end
  if (V_TOTAL > (1 << COORD_W)) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL %0d exceeds the counter range", V_TOTAL);
  end

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               h_wrap_c;
  logic               v_wrap_c;
  logic [CMP_W-1:0]   h_ext;
  logic [CMP_W-1:0]   v_ext;
  vga_out_t           out_q;
  vga_out_t           out_d;

  // Horizontal counter drives the vertical one through its wrap strobe.
  wrap_counter #(.W(COORD_W), .N(H_TOTAL)) u_h_cnt (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .en_i     (i_en),
    .cnt_o    (h_cnt),
    .wrap_c_o (h_wrap_c)
  );

  wrap_counter #(.W(COORD_W), .N(V_TOTAL)) u_v_cnt (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .en_i     (h_wrap_c),
    .cnt_o    (v_cnt),
    .wrap_c_o (v_wrap_c)
  );

  assign h_ext = CMP_W'(h_cnt);
  assign v_ext = CMP_W'(v_cnt);

  // Output decode; v_cnt only moves on the h wrap, so vs is line-aligned.
  always_comb begin
    out_d = out_q;
    if (i_en) begin
      out_d.de  = (h_ext < H_DE_END) && (v_ext < V_DE_END);
      out_d.hs  = ((h_ext >= HS_START) && (h_ext < HS_END)) ? HS_POL : ~HS_POL;
      out_d.vs  = ((v_ext >= VS_START) && (v_ext < VS_END)) ? VS_POL : ~VS_POL;
      out_d.sol = (h_cnt == '0);
      out_d.sof = (h_cnt == '0) && (v_cnt == '0);
      out_d.x   = h_cnt;
      out_d.y   = v_cnt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) out_q <= OUT_RST;
    else         out_q <= out_d;
  end

  assign o_de  = out_q.de;
  assign o_hs  = out_q.hs;
  assign o_vs  = out_q.vs;
  assign o_sol = out_q.sol;
  assign o_sof = out_q.sof;
  assign o_x   = out_q.x;
  assign o_y   = out_q.y;

`ifdef VGA_TIMING_FRAME_CNT_EN
  // frame_cnt_q steps as the counters fold to (0,0); copying it into the
  // output register one edge later lines the change up with o_sof.
  logic [FRAME_W-1:0] frame_cnt_q;
  logic [FRAME_W-1:0] frame_cnt_d;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    frame_d     = frame_q;
    if (v_wrap_c) frame_cnt_d = frame_cnt_q + FRAME_W'(1);
    if (i_en)     frame_d     = frame_cnt_q;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      frame_cnt_q <= '0;
      frame_q     <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      frame_q     <= frame_d;
    end
  end

  assign o_frame = frame_q;
`else
  logic unused_v_wrap_c;
  assign unused_v_wrap_c = v_wrap_c;
`endif

endmodule
